// File: rtl/alu_op_issue.sv
// ---------------------------------------------------------------------------
// alu_op_issue
//
// Issue stage between instruction fetch and the ALU of the single-cycle
// RV32I datapath. Each accepted instruction word is decoded into the control
// bundle the ALU consumes (func code, operand selects, immediate, branch
// flags) and is held in a registered buffer until the consumer takes it.
//
// Handshake (both sides): a transfer happens on a rising edge where
// valid & ready are both high. A producer holding valid keeps its payload
// stable until the transfer; ready may be asserted with or without valid.
//
// Parameters:
//   SKID      - 1: main + skid entries, in_ready is purely registered state
//               (full throughput, no out_ready -> in_ready path).
//               0: single entry, in_ready = ~out_valid | out_ready.
//   STRICT_F7 - 1: non-listed funct7 / imm[11:5] values are illegal.
//               0: only instr[30] selects between the base and alternate op.
//
// Ports:
//   clk, rst          - rising-edge clock, synchronous active-high reset
//   flush             - drop every buffered entry (and any same-cycle accept)
//   in_valid/in_ready - instruction handshake, payload in_instr / in_pc
//   out_valid/out_ready - decoded entry handshake
//   out_func          - ALU op code (ADD=0 .. BLTU=13)
//   out_br_inv        - invert the ALU compare result (BNE/BGE/BGEU)
//   out_is_branch     - conditional branch
//   out_a_sel         - operand A: 0 rs1, 1 pc, 2 zero
//   out_b_sel         - operand B: 0 rs2, 1 imm
//   out_imm           - sign-extended immediate
//   out_pc            - PC of the instruction
//   out_illegal       - undecodable instruction (all controls forced to 0)
// ---------------------------------------------------------------------------
module alu_op_issue #(
    parameter int SKID      = 1,
    parameter int STRICT_F7 = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_func,
    output logic        out_br_inv,
    output logic        out_is_branch,
    output logic [1:0]  out_a_sel,
    output logic        out_b_sel,
    output logic [31:0] out_imm,
    output logic [31:0] out_pc,
    output logic        out_illegal
);

    // ALU function codes
    localparam logic [3:0] ALU_ADD      = 4'd0;
    localparam logic [3:0] ALU_SUB      = 4'd1;
    localparam logic [3:0] ALU_SLL      = 4'd2;
    localparam logic [3:0] ALU_SLT      = 4'd3;
    localparam logic [3:0] ALU_SLTU     = 4'd4;
    localparam logic [3:0] ALU_XOR      = 4'd5;
    localparam logic [3:0] ALU_SRL      = 4'd6;
    localparam logic [3:0] ALU_SRA      = 4'd7;
    localparam logic [3:0] ALU_OR       = 4'd8;
    localparam logic [3:0] ALU_AND      = 4'd9;
    localparam logic [3:0] ALU_ADD_JALR = 4'd10;
    localparam logic [3:0] ALU_BEQ      = 4'd11;
    localparam logic [3:0] ALU_BLT      = 4'd12;
    localparam logic [3:0] ALU_BLTU     = 4'd13;

    // Operand A selects
    localparam logic [1:0] A_RS1  = 2'd0;
    localparam logic [1:0] A_PC   = 2'd1;
    localparam logic [1:0] A_ZERO = 2'd2;

    // Opcodes
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam bit STRICT  = (STRICT_F7 != 0);
    localparam bit USE_SKID = (SKID != 0);

    // One buffered entry: the decoded control bundle plus its PC.
    typedef struct packed {
        logic [3:0]  func;
        logic        br_inv;
        logic        is_branch;
        logic [1:0]  a_sel;
        logic        b_sel;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        illegal;
    } entry_t;

    // ------------------------------------------------------------------
    // Combinational decode of in_instr
    // ------------------------------------------------------------------
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        f7_base;   // f7 / imm[11:5] == 0x00
    logic        f7_alt;    // f7 / imm[11:5] == 0x20
    logic        f7_pick;   // choose the alternate op (SUB / SRA)
    logic        f7_bad;    // neither listed value, only matters when strict

    assign opcode = in_instr[6:0];
    assign f3     = in_instr[14:12];
    assign f7     = in_instr[31:25];

    assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                    in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u = {in_instr[31:12], 12'b0};
    assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                    in_instr[20], in_instr[30:21], 1'b0};

    assign f7_base = (f7 == 7'h00);
    assign f7_alt  = (f7 == 7'h20);
    assign f7_pick = STRICT ? f7_alt : in_instr[30];
    assign f7_bad  = STRICT & ~(f7_base | f7_alt);

    // Base funct3 mapping shared by OP and OP-IMM; the alternate ops
    // (SUB, SRA) are patched in by the caller.
    function automatic logic [3:0] f3_to_func(input logic [2:0] f);
        logic [3:0] r;
        case (f)
            3'b000:  r = ALU_ADD;
            3'b001:  r = ALU_SLL;
            3'b010:  r = ALU_SLT;
            3'b011:  r = ALU_SLTU;
            3'b100:  r = ALU_XOR;
            3'b101:  r = ALU_SRL;
            3'b110:  r = ALU_OR;
            default: r = ALU_AND;
        endcase
        return r;
    endfunction

    entry_t dec;

    always_comb begin
        dec           = '0;
        dec.func      = ALU_ADD;
        dec.a_sel     = A_RS1;
        dec.pc        = in_pc;

        case (opcode)
            OPC_OP: begin
                dec.func = f3_to_func(f3);
                case (f3)
                    3'b000: begin
                        dec.func    = f7_pick ? ALU_SUB : ALU_ADD;
                        dec.illegal = f7_bad;
                    end
                    3'b101: begin
                        dec.func    = f7_pick ? ALU_SRA : ALU_SRL;
                        dec.illegal = f7_bad;
                    end
                    default: dec.illegal = STRICT & ~f7_base;
                endcase
            end

            OPC_OP_IMM: begin
                // f3 000 is always ADDI: bit 30 is just an immediate bit here.
                dec.func  = f3_to_func(f3);
                dec.b_sel = 1'b1;
                dec.imm   = imm_i;
                case (f3)
                    3'b001: dec.illegal = STRICT & ~f7_base;
                    3'b101: begin
                        dec.func    = f7_pick ? ALU_SRA : ALU_SRL;
                        dec.illegal = f7_bad;
                    end
                    default: dec.illegal = 1'b0;
                endcase
            end

            OPC_LOAD: begin
                dec.b_sel = 1'b1;
                dec.imm   = imm_i;
            end

            OPC_STORE: begin
                dec.b_sel = 1'b1;
                dec.imm   = imm_s;
            end

            OPC_LUI: begin
                dec.a_sel = A_ZERO;
                dec.b_sel = 1'b1;
                dec.imm   = imm_u;
            end

            OPC_AUIPC: begin
                dec.a_sel = A_PC;
                dec.b_sel = 1'b1;
                dec.imm   = imm_u;
            end

            OPC_JAL: begin
                dec.a_sel = A_PC;
                dec.b_sel = 1'b1;
                dec.imm   = imm_j;
            end

            OPC_JALR: begin
                dec.func    = ALU_ADD_JALR;
                dec.b_sel   = 1'b1;
                dec.imm     = imm_i;
                dec.illegal = (f3 != 3'b000);
            end

            OPC_BRANCH: begin
                // ALU compares rs1/rs2; the target adder takes imm separately.
                dec.is_branch = 1'b1;
                dec.imm       = imm_b;
                dec.br_inv    = f3[0];
                case (f3[2:1])
                    2'b00:   dec.func = ALU_BEQ;
                    2'b10:   dec.func = ALU_BLT;
                    2'b11:   dec.func = ALU_BLTU;
                    default: dec.illegal = 1'b1;   // f3 010 / 011
                endcase
            end

            default: dec.illegal = 1'b1;
        endcase

        // Illegal words travel with a clean, inert control bundle.
        if (dec.illegal) begin
            dec.func      = ALU_ADD;
            dec.br_inv    = 1'b0;
            dec.is_branch = 1'b0;
            dec.a_sel     = A_RS1;
            dec.b_sel     = 1'b0;
            dec.imm       = '0;
        end
    end

    // ------------------------------------------------------------------
    // Output buffer: main entry drives the outputs, skid catches the word
    // accepted while main is stalled.
    // ------------------------------------------------------------------
    entry_t main_q, skid_q;
    logic   main_valid, skid_valid;
    logic   accept, pop;

    // in_ready depends only on registers (and rst) in skid mode, so no
    // combinational path runs from out_ready back to the producer.
    always_comb begin
        if (USE_SKID) in_ready = ~skid_valid & ~rst;
        else          in_ready = (~main_valid | out_ready) & ~rst;
    end

    assign accept = in_valid & in_ready;
    assign pop    = main_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            // Flush wins over push and pop; stale data may remain but is
            // never visible because out_valid is low.
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (USE_SKID) begin
            if (pop) begin
                if (skid_valid) begin
                    // in_ready is low while skid is full, so no accept here.
                    main_q     <= skid_q;
                    skid_valid <= 1'b0;
                end else if (accept) begin
                    main_q <= dec;
                end else begin
                    main_valid <= 1'b0;
                end
            end else if (accept) begin
                if (!main_valid) begin
                    main_q     <= dec;
                    main_valid <= 1'b1;
                end else begin
                    skid_q     <= dec;
                    skid_valid <= 1'b1;
                end
            end
        end else begin
            if (accept) begin
                main_q     <= dec;
                main_valid <= 1'b1;
            end else if (pop) begin
                main_valid <= 1'b0;
            end
        end
    end

    assign out_valid     = main_valid;
    assign out_func      = main_q.func;
    assign out_br_inv    = main_q.br_inv;
    assign out_is_branch = main_q.is_branch;
    assign out_a_sel     = main_q.a_sel;
    assign out_b_sel     = main_q.b_sel;
    assign out_imm       = main_q.imm;
    assign out_pc        = main_q.pc;
    assign out_illegal   = main_q.illegal;

endmodule

// File: doc/alu_op_issue.md
# alu_op_issue

Instruction-to-ALU issue stage for the single-cycle RISC-V datapath. It accepts 32-bit RV32I instruction words with their PC over a valid/ready handshake. For each word it produces the 4-bit ALU `func` code, the operand selects and the decoded immediate, which are exactly the control inputs the ALU consumes. Results sit in a registered 2-entry skid buffer, so fetch and execute can stall independently at full throughput.

## Interface
Parameters:
- `SKID`, default 1: 1 gives a 2-entry buffer (main + skid); 0 gives a single register with `in_ready = ~out_valid | out_ready`.
- `STRICT_F7`, default 1: 1 flags any non-listed funct7 / imm[11:5] as illegal; 0 decodes using bit 30 only.

Ports:
- `clk`, in, 1: sole clock, rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `flush`, in, 1: synchronous discard of all buffered entries.
- `in_valid`, in, 1: instruction present.
- `in_ready`, out, 1: stage can accept.
- `in_instr`, in, 32: instruction word.
- `in_pc`, in, 32: instruction address.
- `out_valid`, out, 1: decoded entry present.
- `out_ready`, in, 1: consumer accepts.
- `out_func`, out, 4: ALU op. ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, ADD_JALR=10, BEQ=11, BLT=12, BLTU=13.
- `out_br_inv`, out, 1: invert ALU compare flag (BNE/BGE/BGEU).
- `out_is_branch`, out, 1: conditional branch.
- `out_a_sel`, out, 2: 0 = rs1, 1 = pc, 2 = zero.
- `out_b_sel`, out, 1: 0 = rs2, 1 = imm.
- `out_imm`, out, 32: sign-extended immediate.
- `out_pc`, out, 32: passthrough PC.
- `out_illegal`, out, 1: undecodable instruction.

## Operation
Decode is combinational on `in_instr` and registered on acceptance. The fields used are opcode = [6:0], f3 = [14:12] and f7 = [31:25].

- OP (0110011), b_sel = 0:
  - f3 000 gives ADD (f7 = 0x00) or SUB (0x20).
  - f3 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND.
  - f3 101 gives SRL (0x00) or SRA (0x20).
  - With STRICT_F7 = 1, any other f7 is illegal.
- OP-IMM (0010011): same mapping with imm = I-type and b_sel = 1. There is no SUB. SLLI/SRLI need imm[11:5] = 0x00 and SRAI needs 0x20.
- LOAD (0000011): ADD with I-imm. STORE (0100011): ADD with S-imm. Both use a_sel = rs1, b_sel = 1.
- LUI (0110111): ADD, a_sel = zero, U-imm ({instr[31:12], 12'b0}).
- AUIPC (0010111): ADD, a_sel = pc, U-imm.
- JAL (1101111): ADD, a_sel = pc, J-imm.
- JALR (1100111): ADD_JALR, a_sel = rs1, I-imm. f3 must be 000, otherwise illegal.
- BRANCH (1100011): is_branch = 1, B-imm passed, a_sel = rs1, b_sel = 0.
  - f3 000 BEQ, 001 BEQ + inv, 100 BLT, 101 BLT + inv, 110 BLTU, 111 BLTU + inv.
  - f3 010/011 is illegal.
- Any other opcode, including 0x00000000 and 0xFFFFFFFF, is illegal.
- Illegal entries still flow through the buffer. They carry func = 0, a_sel = 0, b_sel = 0, imm = 0, br_inv = 0, is_branch = 0 and illegal = 1.
- Buffer (SKID = 1):
  - On accept (`in_valid & in_ready`), the entry goes to main if main is empty or is being popped this cycle; otherwise it goes to skid.
  - On pop (`out_valid & out_ready`) with skid full, skid moves to main.
  - `in_ready = ~skid_valid`, taken from a register, with no combinational path from `out_ready`.
  - Outputs always reflect main, so order is preserved.
- `flush`: on the next edge main and skid are both empty. An accept in the same cycle is discarded. `flush` outranks push and pop.

## Timing
- Reset:
  - While `rst` is high, `in_ready` = 0.
  - At the first edge with `rst` high, `out_valid` = 0 and all data outputs are 0.
  - `in_ready` = 1 in the first cycle after `rst` falls.
- Latency is 1 cycle: a word accepted at edge N is presented with `out_valid` = 1 after edge N.
- Throughput is 1 instruction per cycle with `out_ready` held high.
- Stall: outputs hold stable while `out_valid & ~out_ready`.
- Fill: with `out_ready` = 0, two words are accepted and then `in_ready` = 0. `in_ready` returns to 1 the cycle after the first pop.
- Simultaneous push and pop with main full and skid empty: the new word enters main and skid stays empty.
- Simultaneous push and pop with skid full: no push occurs, because `in_ready` is 0.
- Reset asserted mid-stream: same behaviour as flush, plus `in_ready` = 0 while `rst` is high.
- All immediates are 32-bit sign-extended from instr[31]. B- and J-immediates have bit 0 = 0.

## Test plan
- `in_instr` = 0x40B50533 (sub) -> one cycle later: func = 1, a_sel = 0, b_sel = 0, illegal = 0.
- 0xFFF00093 (addi x1,x0,-1) -> func = 0, b_sel = 1, imm = 0xFFFFFFFF. 0x123452B7 (lui) -> func = 0, a_sel = 2, imm = 0x12345000.
- 0x00B57463 (bgeu a0,a1,+8) -> func = 13, br_inv = 1, is_branch = 1, imm = 0x00000008. 0x00B51463 (bne) -> func = 11, br_inv = 1.
- 0x00000000, 0x02B50533 (f7 = 0x01, STRICT_F7 = 1) and 0x0000A063 (branch f3 = 010) -> each gives illegal = 1, func = 0.
- `out_ready` = 0, push A, B, C back-to-back:
  - A and B are accepted, then `in_ready` = 0 and C is held.
  - Release `out_ready`: outputs A, B, C in order on consecutive cycles with no gaps.
- Fill both entries, assert `flush` together with `in_valid` -> next cycle `out_valid` = 0 and the pushed word is lost. Repeat with `rst` -> `in_ready` = 0 during reset and 1 the cycle after.
